// File: rtl/phys_reg_file.sv
// Physical register file for the out-of-order core: per-entry {valid, value},
// 2N bypassed combinational read ports, N write ports, N invalidate ports.
module phys_reg_file #(
    parameter int N           = 2,
    parameter int PHYS_REG_SZ = 64,
    parameter int DATA_W      = 32,
    parameter int PRN_W       = $clog2(PHYS_REG_SZ)
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [2*N-1:0][PRN_W-1:0]             read_prn,
    output logic [2*N-1:0][DATA_W:0]              output_value,
    input  logic [N-1:0][DATA_W+PRN_W-1:0]        write_data,
    input  logic [N-1:0][PRN_W-1:0]               prn_invalid,
    output logic [PHYS_REG_SZ-1:0][DATA_W:0]      entries_out,
    output logic [PRN_W-1:0]                      counter
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] value;
    } entry_t;

    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic [PRN_W-1:0]  prn;
    } write_t;

    entry_t [PHYS_REG_SZ-1:0] entries;
    entry_t [PHYS_REG_SZ-1:0] entries_nxt;
    write_t [N-1:0]           wr;
    logic   [PRN_W-1:0]       count_nxt;

    assign wr          = write_data;
    assign entries_out = entries;

    // Invalidates are applied before writes so a same-edge write wins, and
    // writes go in ascending port order so the highest index wins.
    // NOTE: always_comb uses blocking assignments, with a default for every
    // variable first, so later statements override earlier ones and no latch forms.
    always_comb begin
        entries_nxt = entries;
        for (int i = 0; i < N; i++) begin
            if (prn_invalid[i] != '0) entries_nxt[prn_invalid[i]].valid = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (wr[i].prn != '0) begin
                entries_nxt[wr[i].prn].valid = 1'b1;
                entries_nxt[wr[i].prn].value = wr[i].value;
            end
        end
        entries_nxt[0] = '0;
    end

    // Entry 0 is forced invalid above, so counting from 1 keeps it out.
    always_comb begin
        count_nxt = '0;
        for (int p = 1; p < PHYS_REG_SZ; p++) begin
            count_nxt = count_nxt + PRN_W'(entries_nxt[p].valid);
        end
    end

    // NOTE: the storage array is reset here because cleared values are
    // observable on entries_out; sequential state uses non-blocking updates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entries <= '0;
            counter <= '0;
        end else begin
            entries <= entries_nxt;
            counter <= count_nxt;
        end
    end

    // Reads forward same-cycle write data; invalidates are not forwarded.
    always_comb begin
        output_value = '0;
        for (int k = 0; k < 2*N; k++) begin
            output_value[k] = entries[read_prn[k]];
            for (int i = 0; i < N; i++) begin
                if (wr[i].prn == read_prn[k]) output_value[k] = {1'b1, wr[i].value};
            end
            if (read_prn[k] == '0) output_value[k] = '0;
        end
    end

endmodule

// File: tb/tb_phys_reg_file.sv
// Directed self-checking bench for phys_reg_file: reset, fill, reads with
// bypass, same-edge conflicts, invalidates and asynchronous reset.
module tb_phys_reg_file;

    localparam int N           = 2;
    localparam int PHYS_REG_SZ = 64;
    localparam int DATA_W      = 32;
    localparam int PRN_W       = 6;

    logic                                  clock;
    logic                                  reset;
    logic [2*N-1:0][PRN_W-1:0]             read_prn;
    logic [2*N-1:0][DATA_W:0]              output_value;
    logic [N-1:0][DATA_W+PRN_W-1:0]        write_data;
    logic [N-1:0][PRN_W-1:0]               prn_invalid;
    logic [PHYS_REG_SZ-1:0][DATA_W:0]      entries_out;
    logic [PRN_W-1:0]                      counter;

    phys_reg_file #(
        .N(N), .PHYS_REG_SZ(PHYS_REG_SZ), .DATA_W(DATA_W), .PRN_W(PRN_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .read_prn(read_prn),
        .output_value(output_value),
        .write_data(write_data),
        .prn_invalid(prn_invalid),
        .entries_out(entries_out),
        .counter(counter)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int tests  = 0;
    int errors = 0;

    logic [PHYS_REG_SZ-1:0] mvalid;
    logic [DATA_W-1:0]      mvalue [PHYS_REG_SZ];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int p = 1; p < PHYS_REG_SZ; p++) c += int'(mvalid[p]);
        return c;
    endfunction

    task automatic check_state();
        for (int p = 0; p < PHYS_REG_SZ; p++)
            check($sformatf("entry%0d", p), 64'(entries_out[p]), {31'b0, mvalid[p], mvalue[p]});
        check("counter", 64'(counter), 64'(model_count()));
    endtask

    // Valid bit always compared; value only when valid is expected.
    task automatic check_read(input int k, input logic exp_valid, input logic [DATA_W-1:0] exp_value);
        check($sformatf("read%0d_valid", k), 64'(output_value[k][DATA_W]), 64'(exp_valid));
        if (exp_valid)
            check($sformatf("read%0d_value", k), 64'(output_value[k][DATA_W-1:0]), 64'(exp_value));
    endtask

    task automatic check_read_model(input int k);
        int p = int'(read_prn[k]);
        if (p == 0) check_read(k, 1'b0, '0);
        else        check_read(k, mvalid[p], mvalue[p]);
    endtask

    task automatic set_write(input int i, input int prn, input logic [DATA_W-1:0] data);
        write_data[i] = {data, PRN_W'(prn)};
    endtask

    // Model computes next state from the driven inputs, then one edge passes.
    task automatic tick();
        logic [PHYS_REG_SZ-1:0] nv;
        logic [DATA_W-1:0]      nval [PHYS_REG_SZ];
        int p;
        nv   = mvalid;
        nval = mvalue;
        for (int i = 0; i < N; i++)
            if (prn_invalid[i] != '0) nv[prn_invalid[i]] = 1'b0;
        for (int i = 0; i < N; i++) begin
            p = int'(write_data[i][PRN_W-1:0]);
            if (p != 0) begin
                nv[p]   = 1'b1;
                nval[p] = write_data[i][DATA_W+PRN_W-1:PRN_W];
            end
        end
        @(posedge clock);
        #1;
        mvalid = nv;
        mvalue = nval;
        check_state();
    endtask

    task automatic clear_inputs();
        write_data  = '0;
        prn_invalid = '0;
        read_prn    = '0;
    endtask

    int inv_list [10][2] = '{'{0, 7}, '{9, 9}, '{3, 0}, '{7, 12}, '{0, 0},
                             '{20, 21}, '{63, 1}, '{12, 40}, '{5, 5}, '{2, 63}};
    int rd_list [3][4] = '{'{0, 17, 63, 42}, '{1, 2, 62, 0}, '{33, 33, 8, 50}};

    initial begin
        mvalid = '0;
        for (int p = 0; p < PHYS_REG_SZ; p++) mvalue[p] = '0;
        clear_inputs();

        // Reset held for two cycles.
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_state();
        for (int k = 0; k < 2*N; k++) check_read(k, 1'b0, '0);
        check("reset_read0_raw", 64'(output_value[0]), 64'd0);
        reset = 1'b1;

        // Fill every entry; p0 write is ignored.
        for (int c = 0; c < PHYS_REG_SZ/N; c++) begin
            for (int j = 0; j < N; j++) set_write(j, c*N + j, $urandom);
            tick();
        end
        write_data = '0;
        check("fill_count", 64'(counter), 64'd63);

        // Combinational reads, no edge.
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 2*N; k++) read_prn[k] = PRN_W'(rd_list[s][k]);
            #2;
            for (int k = 0; k < 2*N; k++) check_read_model(k);
        end

        // Bypass: invalidate p4, then write p1 while reading p1/p3/p4/p0.
        prn_invalid[0] = PRN_W'(4);
        tick();
        prn_invalid = '0;
        set_write(0, 1, 32'hDEADBEEF);
        set_write(1, 0, 32'h12345678);
        read_prn[0] = PRN_W'(1);
        read_prn[1] = PRN_W'(3);
        read_prn[2] = PRN_W'(4);
        read_prn[3] = PRN_W'(0);
        #2;
        check_read(0, 1'b1, 32'hDEADBEEF);
        check_read(1, 1'b1, mvalue[3]);
        check_read(2, 1'b0, '0);
        check("bypass_p0_raw", 64'(output_value[3]), 64'd0);
        tick();
        check("bypass_p1_state", 64'(entries_out[1]), {31'b0, 1'b1, 32'hDEADBEEF});
        check("bypass_count", 64'(counter), 64'd62);

        // Conflict: two writes and an invalidate to p5 in one cycle.
        set_write(0, 5, 32'h11);
        set_write(1, 5, 32'h22);
        prn_invalid[0] = PRN_W'(5);
        read_prn[0]    = PRN_W'(5);
        #2;
        check_read(0, 1'b1, 32'h22);
        tick();
        check("conflict_p5", 64'(entries_out[5]), {31'b0, 1'b1, 32'h22});
        check("conflict_count", 64'(counter), 64'd62);
        clear_inputs();

        // Invalidates including p0 and duplicates.
        for (int s = 0; s < 10; s++) begin
            prn_invalid[0] = PRN_W'(inv_list[s][0]);
            prn_invalid[1] = PRN_W'(inv_list[s][1]);
            tick();
        end
        prn_invalid = '0;
        check("inv_count", 64'(counter), 64'd51);
        check("inv_p4_still_invalid", 64'(entries_out[4][DATA_W]), 64'd0);

        // Asynchronous reset between edges.
        #2;
        reset = 1'b0;
        #1;
        check("async_counter", 64'(counter), 64'd0);
        check("async_entry1", 64'(entries_out[1]), 64'd0);
        check("async_entry63", 64'(entries_out[63]), 64'd0);
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
